alu_rr_sequencer: RTL and testbench
===================================

Name: alu_rr_sequencer

Overview:
- Shares one combinational ALU instance among NUM_REQ requesters using round-robin arbitration and valid/ready handshakes.
- Registers the chosen operation's result, zero flag and requester ID into a single response channel with backpressure.
- Sits between multi-cycle datapath clients (address-gen, branch-compare, debug) and the shared ALU, so only one ALU is needed.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- SIZE, 32, operand/result width; passed to ALU.
- ID_W, 2, width of resp_id; must satisfy 2**ID_W >= NUM_REQ.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; at most one bit set (one-hot or zero).
- req_a  in  NUM_REQ*SIZE  packed operand A; slice i belongs to requester i.
- req_b  in  NUM_REQ*SIZE  packed operand B.
- req_func  in  NUM_REQ*4  packed ALU function codes.
- resp_valid  out  1  response valid.
- resp_ready  in  1  response consumer ready.
- resp_data  out  SIZE  registered ALU result.
- resp_zero  out  1  registered zero flag (resp_data == 0).
- resp_id  out  ID_W  index of the requester that owns the response.

Behaviour:
- Reset: asynchronous and active-low; clk is the only clock.
  - All outputs reset to 0: resp_valid, resp_data, resp_zero, resp_id, req_ready.
  - Round-robin pointer ptr resets to 0; state resets to IDLE.
  - Asserting rst_n low mid-operation discards any held response with no partial output.
- States:
  - IDLE: resp_valid=0.
  - HOLD: resp_valid=1; response registers are stable until consumed.
- can_accept = (state==IDLE) | resp_ready.
- Grant (combinational):
  - Winner = first i with req_valid[i], scanning ptr, ptr+1, ... modulo NUM_REQ.
  - req_ready[winner] = can_accept; all other bits 0.
  - No valid requests means no grant and req_ready all 0.
- Accept (req_valid[w] & req_ready[w] at an edge):
  - resp_data <= ALU(req_a[w], req_b[w], req_func[w]).
  - resp_zero <= (result==0).
  - resp_id <= w.
  - ptr <= (w+1) mod NUM_REQ.
  - state <= HOLD.
- Latency: accept at edge N gives resp_valid=1 after edge N. ALU is combinational, so latency is 1 cycle.
- Throughput: in HOLD with resp_ready=1 and a pending request, consume and accept happen at the same edge. State stays HOLD, giving 1 op/cycle.
- HOLD with resp_ready=1 and no request: state <= IDLE; resp_valid drops and data registers keep their values.
- HOLD with resp_ready=0: everything is held and req_ready is all 0.
- Requesters must keep a/b/func stable while valid and not ready. req_valid may be deasserted before acceptance with no effect.
- ALU function codes:
  - 0 add, 1 sub, 2 and, 3 or, 4 nor, 5 xor.
  - 6 set-less-than unsigned (1/0), 7 b<<16, 8 set-greater-or-equal unsigned (0/1).
  - 9..15 give result 0 and zero=1.
- Arithmetic: modulo 2**SIZE wrap, no carry/overflow output.
- Pointer wrap: after a grant to NUM_REQ-1, ptr returns to 0.

Optional Feature:
- Macro ALU_RR_STATS_EN.
- Defined:
  - Adds output grant_cnt, NUM_REQ*16 bits: one 16-bit saturating counter per requester, +1 on each accept, sticks at 0xFFFF.
  - Counters reset to 0.
  - Adds input stats_clr (1 bit), a synchronous clear of all counters; clear wins over increment in the same cycle.
- Undefined: neither port exists, no counter logic is present, and behaviour is otherwise identical.

Decomposition:
- Package alu_rr_pkg:
  - Localparams for the func codes: ALU_ADD=0, ALU_SUB=1, ALU_AND=2, ALU_OR=3, ALU_NOR=4, ALU_XOR=5, ALU_SLT=6, ALU_LUI=7, ALU_SGE=8.
  - State encoding: IDLE=0, HOLD=1.
  - Counter width constant STAT_W=16.
- Sub-module rr_pick (NUM_REQ):
  - Inputs: req vector and ptr.
  - Outputs: one-hot grant and its binary index.
  - Purely combinational.
- The datapath instantiates the team's existing ALU module (parameter size=SIZE) once; its operands are muxed by the winner index.

Test Plan:
- Reset check: reset asserted mid-HOLD -> resp_valid=0, resp_data=0, resp_id=0 immediately (async); after release, the first grant goes to requester 0.
- Single op: req0 a=5 b=5 func=1, resp_ready=1 -> one cycle later resp_valid=1, resp_data=0, resp_zero=1, resp_id=0.
- Round robin: all 4 req_valid held, resp_ready=1 -> grants in order 0,1,2,3,0 on consecutive cycles; one resp_valid per cycle with ids in the same order.
- Backpressure: req2 a=0xFFFF0000 b=0x0000FFFF func=3, resp_ready=0 for 3 cycles -> resp_data=0xFFFFFFFF stable; req_ready all 0; the next grant happens only at the edge where resp_ready=1.
- Arithmetic edges:
  - a=0xFFFFFFFF b=1 func=0 -> 0, zero=1.
  - a=3 b=0x1234 func=7 -> 0x12340000.
  - func=12 -> 0, zero=1.
  - a=2 b=7 func=8 -> 0.
- Stats (ALU_RR_STATS_EN): 5 grants to req1, then stats_clr and an accept to req1 in the same cycle -> grant_cnt[1]=0 after that edge.

Source files
------------

// File: rtl/alu_rr_pkg.sv
// rtl/alu_rr_pkg.sv - shared ALU function codes, sequencer state encoding and stats width
package alu_rr_pkg;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_NOR = 4'd4;
    localparam logic [3:0] ALU_XOR = 4'd5;
    localparam logic [3:0] ALU_SLT = 4'd6;
    localparam logic [3:0] ALU_LUI = 4'd7;
    localparam logic [3:0] ALU_SGE = 4'd8;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam int STAT_W = 16;

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational ALU; unknown function codes produce zero
module alu
    import alu_rr_pkg::*;
#(
    parameter int size = 32
) (
    input  logic [size-1:0] a,
    input  logic [size-1:0] b,
    input  logic [3:0]      func,
    output logic [size-1:0] result
);

    always_comb begin
        result = '0;
        case (func)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_NOR: result = ~(a | b);
            ALU_XOR: result = a ^ b;
            ALU_SLT: result = (a < b) ? size'(1) : '0;
            ALU_LUI: result = b << 16;
            ALU_SGE: result = (a >= b) ? size'(1) : '0;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin pick starting at ptr; one-hot grant plus index
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx,
    output logic               any
);

    logic            hi_found;
    logic [ID_W-1:0] hi_idx;
    logic [ID_W-1:0] lo_idx;

    // Descending scans leave the lowest matching index: first at/after ptr, else first overall.
    always_comb begin
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                lo_idx = ID_W'(i);
                if (ID_W'(i) >= ptr) begin
                    hi_found = 1'b1;
                    hi_idx   = ID_W'(i);
                end
            end
        end
    end

    always_comb begin
        any       = |req;
        grant_idx = hi_found ? hi_idx : lo_idx;
        grant     = any ? (NUM_REQ'(1) << grant_idx) : '0;
    end

endmodule

// File: rtl/alu_rr_sequencer.sv
// rtl/alu_rr_sequencer.sv - round-robin sharing of one ALU with registered response; ALU_RR_STATS_EN adds grant counters
module alu_rr_sequencer
    import alu_rr_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int SIZE    = 32,
    parameter int ID_W    = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*SIZE-1:0] req_a,
    input  logic [NUM_REQ*SIZE-1:0] req_b,
    input  logic [NUM_REQ*4-1:0]   req_func,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [SIZE-1:0]        resp_data,
    output logic                   resp_zero,
    output logic [ID_W-1:0]        resp_id
`ifdef ALU_RR_STATS_EN
    ,
    input  logic                   stats_clr,
    output logic [NUM_REQ*STAT_W-1:0] grant_cnt
`endif
);

    state_t              state, state_nxt;
    logic [ID_W-1:0]     ptr;
    logic [NUM_REQ-1:0]  grant;
    logic [ID_W-1:0]     win_idx;
    logic                any_req;
    logic                can_accept;
    logic                accept;

    logic [SIZE-1:0]     a_arr    [NUM_REQ];
    logic [SIZE-1:0]     b_arr    [NUM_REQ];
    logic [3:0]          func_arr [NUM_REQ];
    logic [SIZE-1:0]     alu_result;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req       (req_valid),
        .ptr       (ptr),
        .grant     (grant),
        .grant_idx (win_idx),
        .any       (any_req)
    );

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            a_arr[i]    = req_a[i*SIZE +: SIZE];
            b_arr[i]    = req_b[i*SIZE +: SIZE];
            func_arr[i] = req_func[i*4 +: 4];
        end
    end

    alu #(
        .size (SIZE)
    ) u_alu (
        .a      (a_arr[win_idx]),
        .b      (b_arr[win_idx]),
        .func   (func_arr[win_idx]),
        .result (alu_result)
    );

    // rst_n gating keeps req_ready low while reset is held.
    assign can_accept = rst_n & ((state == IDLE) | resp_ready);
    assign accept     = any_req & can_accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = accept ? HOLD : IDLE;
            HOLD:    if (resp_ready) state_nxt = accept ? HOLD : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        resp_valid = (state == HOLD);
        req_ready  = grant & {NUM_REQ{can_accept}};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_data <= '0;
            resp_zero <= 1'b0;
            resp_id   <= '0;
            ptr       <= '0;
        end else if (accept) begin
            resp_data <= alu_result;
            resp_zero <= (alu_result == '0);
            resp_id   <= win_idx;
            ptr       <= (win_idx == ID_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
        end
    end

`ifdef ALU_RR_STATS_EN
    logic [NUM_REQ-1:0][STAT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (stats_clr) begin
            cnt <= '0;
        end else if (accept) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (win_idx == ID_W'(i) && cnt[i] != {STAT_W{1'b1}}) begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    assign grant_cnt = cnt;
`endif

endmodule

// File: tb/tb_alu_rr_sequencer.sv
// tb/tb_alu_rr_sequencer.sv - directed self-checking bench for alu_rr_sequencer
module tb_alu_rr_sequencer;

    logic          clk;
    logic          rst_n;
    logic [3:0]    req_valid;
    logic [3:0]    req_ready;
    logic [127:0]  req_a;
    logic [127:0]  req_b;
    logic [15:0]   req_func;
    logic          resp_valid;
    logic          resp_ready;
    logic [31:0]   resp_data;
    logic          resp_zero;
    logic [1:0]    resp_id;
`ifdef ALU_RR_STATS_EN
    logic          stats_clr;
    logic [63:0]   grant_cnt;
`endif

    int tests_run;
    int tests_failed;

    alu_rr_sequencer #(
        .NUM_REQ (4),
        .SIZE    (32),
        .ID_W    (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_func   (req_func),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_zero  (resp_zero),
        .resp_id    (resp_id)
`ifdef ALU_RR_STATS_EN
        ,
        .stats_clr  (stats_clr),
        .grant_cnt  (grant_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int idx, input logic [31:0] a, input logic [31:0] b, input logic [3:0] f);
        req_a[idx*32 +: 32]  = a;
        req_b[idx*32 +: 32]  = b;
        req_func[idx*4 +: 4] = f;
    endtask

    // One isolated op on requester idx with resp_ready=1, then drain back to IDLE.
    task automatic do_op(input string tag, input int idx, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] f, input logic [31:0] exp_data, input logic exp_zero);
        set_req(idx, a, b, f);
        req_valid      = '0;
        req_valid[idx] = 1'b1;
        resp_ready     = 1'b1;
        step();
        req_valid = '0;
        check_eq({tag, "_data"}, resp_data, exp_data);
        check_eq({tag, "_zero"}, {31'd0, resp_zero}, {31'd0, exp_zero});
        check_eq({tag, "_id"}, {30'd0, resp_id}, idx);
        step();
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n      = 1'b0;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        req_func   = '0;
        resp_ready = 1'b0;
`ifdef ALU_RR_STATS_EN
        stats_clr  = 1'b0;
`endif
        #12;
        check_eq("rst_valid", {31'd0, resp_valid}, 32'd0);
        check_eq("rst_data", resp_data, 32'd0);
        check_eq("rst_ready", {28'd0, req_ready}, 32'd0);
        rst_n = 1'b1;
        step();

        // single op: 5-5 -> 0
        set_req(0, 32'd5, 32'd5, 4'd1);
        req_valid  = 4'b0001;
        resp_ready = 1'b1;
        #1;
        check_eq("single_ready", {28'd0, req_ready}, 32'h1);
        step();
        req_valid = '0;
        check_eq("single_valid", {31'd0, resp_valid}, 32'd1);
        check_eq("single_data", resp_data, 32'd0);
        check_eq("single_zero", {31'd0, resp_zero}, 32'd1);
        check_eq("single_id", {30'd0, resp_id}, 32'd0);
        step();
        check_eq("single_idle", {31'd0, resp_valid}, 32'd0);

        // HOLD on requester 1 (ptr is now 1), then async reset mid-HOLD
        set_req(1, 32'd1, 32'd2, 4'd0);
        req_valid  = 4'b0010;
        resp_ready = 1'b0;
        step();
        check_eq("hold_data", resp_data, 32'd3);
        check_eq("hold_id", {30'd0, resp_id}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_valid", {31'd0, resp_valid}, 32'd0);
        check_eq("midrst_data", resp_data, 32'd0);
        check_eq("midrst_id", {30'd0, resp_id}, 32'd0);
        check_eq("midrst_ready", {28'd0, req_ready}, 32'd0);
        #2;
        rst_n     = 1'b1;
        req_valid = '0;
        step();

        // round robin: all four valid, grants 0,1,2,3,0
        for (int i = 0; i < 4; i++) set_req(i, 32'(10 * i), 32'd100, 4'd0);
        req_valid  = 4'b1111;
        resp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            check_eq($sformatf("rr_ready%0d", k), {28'd0, req_ready}, 32'(1 << (k % 4)));
            step();
            check_eq($sformatf("rr_valid%0d", k), {31'd0, resp_valid}, 32'd1);
            check_eq($sformatf("rr_id%0d", k), {30'd0, resp_id}, 32'(k % 4));
            check_eq($sformatf("rr_data%0d", k), resp_data, 32'(10 * (k % 4) + 100));
        end
        req_valid = '0;
        step();
        check_eq("rr_idle", {31'd0, resp_valid}, 32'd0);
        check_eq("rr_keep", resp_data, 32'd100);

        // backpressure on requester 2 (ptr is 1)
        set_req(2, 32'hFFFF0000, 32'h0000FFFF, 4'd3);
        req_valid  = 4'b0100;
        resp_ready = 1'b0;
        #1;
        check_eq("bp_ready0", {28'd0, req_ready}, 32'h4);
        step();
        for (int k = 0; k < 3; k++) begin
            check_eq($sformatf("bp_data%0d", k), resp_data, 32'hFFFFFFFF);
            check_eq($sformatf("bp_valid%0d", k), {31'd0, resp_valid}, 32'd1);
            check_eq($sformatf("bp_ready%0d", k), {28'd0, req_ready}, 32'd0);
            step();
        end
        set_req(2, 32'h0000000F, 32'h000000F0, 4'd5);
        resp_ready = 1'b1;
        #1;
        check_eq("bp_release", {28'd0, req_ready}, 32'h4);
        step();
        req_valid = '0;
        check_eq("bp_next_data", resp_data, 32'h000000FF);
        check_eq("bp_next_valid", {31'd0, resp_valid}, 32'd1);
        step();

        do_op("add_wrap", 3, 32'hFFFFFFFF, 32'd1, 4'd0, 32'd0, 1'b1);
        do_op("lui", 3, 32'd3, 32'h1234, 4'd7, 32'h12340000, 1'b0);
        do_op("func12", 3, 32'd7, 32'd9, 4'd12, 32'd0, 1'b1);
        do_op("sge", 3, 32'd2, 32'd7, 4'd8, 32'd0, 1'b1);
        do_op("sge_eq", 3, 32'd7, 32'd7, 4'd8, 32'd1, 1'b0);
        do_op("slt", 3, 32'd2, 32'hFFFFFFF0, 4'd6, 32'd1, 1'b0);
        do_op("sub_neg", 3, 32'd3, 32'd5, 4'd1, 32'hFFFFFFFE, 1'b0);
        do_op("nor", 3, 32'h0F0F0000, 32'h00000F0F, 4'd4, 32'hF0F0F0F0, 1'b0);
        do_op("and", 3, 32'h0000F0F0, 32'h0000FF00, 4'd2, 32'h0000F000, 1'b0);

`ifdef ALU_RR_STATS_EN
        stats_clr = 1'b1;
        step();
        stats_clr = 1'b0;
        set_req(1, 32'd1, 32'd1, 4'd0);
        resp_ready = 1'b1;
        req_valid  = 4'b0010;
        for (int k = 0; k < 5; k++) step();
        check_eq("stat_cnt5", {16'd0, grant_cnt[31:16]}, 32'd5);
        stats_clr = 1'b1;
        step();
        stats_clr = 1'b0;
        req_valid = '0;
        check_eq("stat_clr", {16'd0, grant_cnt[31:16]}, 32'd0);
        step();
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
